// File: rtl/instr_decode_mips_if.sv
// Fetch/decode/execute/RF-port bundle for the MIPS decode stage.
// master = the decode stage; slave = its neighbours (fetch, RF, writeback, execute).
// Widths follow DATA_W and RF_ADDR_W; writeback index is always 5 bits.
interface instr_decode_mips_if #(
  parameter int DATA_W    = 32,
  parameter int RF_ADDR_W = 6
);
  // fetch side
  logic                 if_valid;
  logic [DATA_W-1:0]    if_instr;
  logic [DATA_W-1:0]    if_pc;
  logic                 if_ready;
  logic                 flush;
  // register file read ports
  logic                 r_1_en;
  logic [RF_ADDR_W-1:0] addr_r_1;
  logic [DATA_W-1:0]    r_data_1;
  logic                 r_2_en;
  logic [RF_ADDR_W-1:0] addr_r_2;
  logic [DATA_W-1:0]    r_data_2;
  // writeback snoop
  logic                 wb_en;
  logic [4:0]           wb_addr;
  logic [DATA_W-1:0]    wb_data;
  // ID/EX bundle
  logic                 ex_ready;
  logic                 id_valid;
  logic [DATA_W-1:0]    id_pc;
  logic [DATA_W-1:0]    id_rs_data;
  logic [DATA_W-1:0]    id_rt_data;
  logic [DATA_W-1:0]    id_imm;
  logic [5:0]           id_opcode;
  logic [5:0]           id_funct;
  logic [4:0]           id_dst;
  logic                 id_reg_write;

  modport master (
    input  if_valid, if_instr, if_pc, flush, r_data_1, r_data_2,
           wb_en, wb_addr, wb_data, ex_ready,
    output if_ready, r_1_en, addr_r_1, r_2_en, addr_r_2,
           id_valid, id_pc, id_rs_data, id_rt_data, id_imm,
           id_opcode, id_funct, id_dst, id_reg_write
  );

  modport slave (
    output if_valid, if_instr, if_pc, flush, r_data_1, r_data_2,
           wb_en, wb_addr, wb_data, ex_ready,
    input  if_ready, r_1_en, addr_r_1, r_2_en, addr_r_2,
           id_valid, id_pc, id_rs_data, id_rt_data, id_imm,
           id_opcode, id_funct, id_dst, id_reg_write
  );
endinterface

// File: rtl/instr_decode_mips.sv
// MIPS decode stage: reads rs/rt from the RF, bypasses writeback, presents a decoded ID/EX bundle.
// Latency: accept -> id_valid in 2 cycles; at most one instruction every 2 cycles.
// Backpressure: ex_ready low holds the bundle (operands still track writeback) and blocks fetch.
module instr_decode_mips #(
  parameter int DATA_W    = 32,
  parameter int RF_ADDR_W = 6
) (
  input logic                clk,
  input logic                rst,
  instr_decode_mips_if.master bus
);

  localparam int PAD_W = RF_ADDR_W - 5;

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, VALID = 2'd2} state_t;

  state_t            state_q, state_d;
  logic              if_ready, accept, capture, hold_upd;
  logic [DATA_W-1:0] instr_q, pc_q;

  logic [5:0]        op;
  logic [4:0]        dst_dec;
  logic              rw_dec;
  logic [DATA_W-1:0] imm_dec;

  logic [DATA_W-1:0] rs_q, rt_q, pco_q, imm_q;
  logic [5:0]        opc_q, fn_q;
  logic [4:0]        dst_q;
  logic              rw_q;

  // $0 reads as zero; a same-cycle writeback to the register wins over the stale value.
  function automatic logic [DATA_W-1:0] operand(input logic [4:0] idx, input logic [DATA_W-1:0] base,
                                                input logic w_en, input logic [4:0] w_idx,
                                                input logic [DATA_W-1:0] w_dat);
    if (idx == 5'd0)              return '0;
    else if (w_en && w_idx == idx) return w_dat;
    else                           return base;
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and handshake decisions; flush overrides everything else.
  always_comb begin
    state_d  = state_q;
    if_ready = 1'b0;
    capture  = 1'b0;
    hold_upd = 1'b0;
    case (state_q)
      IDLE:  if_ready = 1'b1;
      READ:  begin
        capture = 1'b1;
        state_d = VALID;
      end
      VALID: begin
        if_ready = bus.ex_ready;
        if (bus.ex_ready) state_d = IDLE;
        else              hold_upd = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    accept = bus.if_valid && if_ready && !bus.flush;
    if (accept) state_d = READ;
    if (bus.flush) begin
      state_d  = IDLE;
      capture  = 1'b0;
      hold_upd = 1'b0;
    end
  end

  // Latch the accepted instruction; its rs/rt fields also keep the RF addresses stable afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= '0;
      pc_q    <= '0;
    end else if (accept) begin
      instr_q <= bus.if_instr;
      pc_q    <= bus.if_pc;
    end
  end

  // Decode destination, write enable and extended immediate from the held instruction.
  always_comb begin
    op      = instr_q[31:26];
    dst_dec = 5'd0;
    rw_dec  = 1'b0;
    case (op)
      6'h00: begin
        dst_dec = instr_q[15:11];
        rw_dec  = (instr_q[5:0] != 6'h08);  // jr writes nothing
      end
      6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23: begin
        dst_dec = instr_q[20:16];
        rw_dec  = 1'b1;
      end
      6'h03: begin
        dst_dec = 5'd31;
        rw_dec  = 1'b1;
      end
      default: ;
    endcase
    if (op == 6'h0C || op == 6'h0D) imm_dec = {{(DATA_W-16){1'b0}}, instr_q[15:0]};
    else                            imm_dec = {{(DATA_W-16){instr_q[15]}}, instr_q[15:0]};
  end

  // ID/EX bundle: loaded when leaving READ, operands refreshed from writeback while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_q  <= '0;
      rt_q  <= '0;
      pco_q <= '0;
      imm_q <= '0;
      opc_q <= '0;
      fn_q  <= '0;
      dst_q <= '0;
      rw_q  <= 1'b0;
    end else if (capture) begin
      rs_q  <= operand(instr_q[25:21], bus.r_data_1, bus.wb_en, bus.wb_addr, bus.wb_data);
      rt_q  <= operand(instr_q[20:16], bus.r_data_2, bus.wb_en, bus.wb_addr, bus.wb_data);
      pco_q <= pc_q;
      imm_q <= imm_dec;
      opc_q <= instr_q[31:26];
      fn_q  <= instr_q[5:0];
      dst_q <= dst_dec;
      rw_q  <= rw_dec;
    end else if (hold_upd) begin
      rs_q  <= operand(instr_q[25:21], rs_q, bus.wb_en, bus.wb_addr, bus.wb_data);
      rt_q  <= operand(instr_q[20:16], rt_q, bus.wb_en, bus.wb_addr, bus.wb_data);
    end
  end

  assign bus.if_ready     = if_ready;
  assign bus.r_1_en       = accept;
  assign bus.r_2_en       = accept;
  assign bus.addr_r_1     = {{PAD_W{1'b0}}, (accept ? bus.if_instr[25:21] : instr_q[25:21])};
  assign bus.addr_r_2     = {{PAD_W{1'b0}}, (accept ? bus.if_instr[20:16] : instr_q[20:16])};
  assign bus.id_valid     = (state_q == VALID);
  assign bus.id_pc        = pco_q;
  assign bus.id_rs_data   = rs_q;
  assign bus.id_rt_data   = rt_q;
  assign bus.id_imm       = imm_q;
  assign bus.id_opcode    = opc_q;
  assign bus.id_funct     = fn_q;
  assign bus.id_dst       = dst_q;
  assign bus.id_reg_write = rw_q;

endmodule

// File: tb/tb_instr_decode_mips.sv
// Bench for instr_decode_mips: directed scenarios, then randomized traffic against a reference model.
// The model tracks accepted instructions in a queue and architectural register values in rf.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_instr_decode_mips;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_decode_mips_if #(.DATA_W(32), .RF_ADDR_W(6)) bus ();
  instr_decode_mips #(.DATA_W(32), .RF_ADDR_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Register file model: written only through the writeback port, read combinationally.
  logic [31:0] rf [32];
  always @(posedge clk) if (bus.wb_en) rf[bus.wb_addr] <= bus.wb_data;
  assign bus.r_data_1 = rf[bus.addr_r_1[4:0]];
  assign bus.r_data_2 = rf[bus.addr_r_2[4:0]];

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  int hs     = 0;
  logic rnd_en = 1'b0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  typedef struct { logic [31:0] instr; logic [31:0] pc; int acc; } ent_t;
  ent_t q[$];
  ent_t e, ne;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Architectural meaning of each instruction, straight from the ISA rules.
  function automatic void ref_decode(input logic [31:0] ins, output logic [4:0] dst,
                                     output logic rw, output logic [31:0] imm);
    logic [5:0] o;
    o = ins[31:26];
    if (o == 6'h00) begin
      dst = ins[15:11];
      rw  = (ins[5:0] != 6'h08);
    end else if (o inside {6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23}) begin
      dst = ins[20:16];
      rw  = 1'b1;
    end else if (o == 6'h03) begin
      dst = 5'd31;
      rw  = 1'b1;
    end else begin
      dst = 5'd0;
      rw  = 1'b0;
    end
    imm = (o inside {6'h0C, 6'h0D}) ? {16'h0, ins[15:0]} : {{16{ins[15]}}, ins[15:0]};
  endfunction

  function automatic logic [31:0] reg_val(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'h0 : rf[idx];
  endfunction

  // Accept one instruction from IDLE and return on the falling edge of its first VALID cycle.
  task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
    bus.if_valid = 1'b1;
    bus.if_instr = ins;
    bus.if_pc    = pc;
    cyc();
    bus.if_valid = 1'b0;
    cyc();
    @(negedge clk);
  endtask

  // Randomized-phase scoreboard: an instruction becomes visible 2 cycles after acceptance
  // and leaves on ex_ready; its operands are the register values at that moment.
  always @(negedge clk) begin
    if (rnd_en) begin
      logic exp_vld, exp_rdy, exp_acc;
      logic [4:0] xd;
      logic xr;
      logic [31:0] xi;
      exp_vld = (q.size() != 0) && (cyc_n - q[0].acc >= 2);
      exp_rdy = (q.size() == 0) || (exp_vld && bus.ex_ready);
      chk("rnd_id_valid", bus.id_valid, exp_vld);
      chk("rnd_if_ready", bus.if_ready, exp_rdy);
      exp_acc = bus.if_valid && exp_rdy && !bus.flush;
      chk("rnd_r_en", {bus.r_1_en, bus.r_2_en}, {exp_acc, exp_acc});
      if (exp_vld && bus.ex_ready && !bus.flush) begin
        e = q.pop_front();
        ref_decode(e.instr, xd, xr, xi);
        chk("rnd_pc", bus.id_pc, e.pc);
        chk("rnd_rs", bus.id_rs_data, reg_val(e.instr[25:21]));
        chk("rnd_rt", bus.id_rt_data, reg_val(e.instr[20:16]));
        chk("rnd_op_fn", {bus.id_opcode, bus.id_funct}, {e.instr[31:26], e.instr[5:0]});
        chk("rnd_dst", bus.id_dst, xd);
        chk("rnd_rw", bus.id_reg_write, xr);
        chk("rnd_imm", bus.id_imm, xi);
        hs++;
      end
      if (bus.flush) q.delete();
      else if (exp_acc) begin
        chk("rnd_addr", {bus.addr_r_1, bus.addr_r_2}, {1'b0, bus.if_instr[25:21], 1'b0, bus.if_instr[20:16]});
        ne.instr = bus.if_instr;
        ne.pc    = bus.if_pc;
        ne.acc   = cyc_n;
        q.push_back(ne);
      end
    end
  end

  logic [5:0] ops [15];
  logic [31:0] ins;

  initial begin
    ops = '{6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23,
            6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h3F};
    rst = 1'b1;
    bus.if_valid = 1'b0; bus.if_instr = '0; bus.if_pc = '0; bus.flush = 1'b0;
    bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0; bus.ex_ready = 1'b1;

    // Preload the register file through writeback while the stage is held in reset.
    for (int i = 0; i < 32; i++) begin
      bus.wb_en   = 1'b1;
      bus.wb_addr = i[4:0];
      bus.wb_data = (i == 10) ? 32'd5 : (i == 11) ? 32'd7 : $urandom;
      cyc();
    end
    bus.wb_en = 1'b0;
    @(negedge clk);
    chk("rst_if_ready", bus.if_ready, 1);
    chk("rst_id_valid", bus.id_valid, 0);
    chk("rst_r_en", {bus.r_1_en, bus.r_2_en}, 0);
    chk("rst_addr", {bus.addr_r_1, bus.addr_r_2}, 0);
    chk("rst_bundle", bus.id_pc | bus.id_rs_data | bus.id_rt_data | bus.id_imm, 0);
    chk("rst_fields", {bus.id_opcode, bus.id_funct, bus.id_dst, bus.id_reg_write}, 0);
    cyc();
    rst = 1'b0;

    // add $9,$10,$11 with $10=5, $11=7
    bus.if_valid = 1'b1; bus.if_instr = 32'h014B4820; bus.if_pc = 32'h100;
    @(negedge clk);
    chk("add_r_en", {bus.r_1_en, bus.r_2_en}, 2'b11);
    chk("add_addr1", bus.addr_r_1, 10);
    chk("add_addr2", bus.addr_r_2, 11);
    cyc();
    bus.if_valid = 1'b0;
    @(negedge clk);
    chk("add_r_en_pulse", {bus.r_1_en, bus.r_2_en}, 0);
    chk("add_read_valid", bus.id_valid, 0);
    chk("add_addr_hold", bus.addr_r_1, 10);
    cyc();
    @(negedge clk);
    chk("add_valid", bus.id_valid, 1);
    chk("add_rs", bus.id_rs_data, 5);
    chk("add_rt", bus.id_rt_data, 7);
    chk("add_dst", bus.id_dst, 9);
    chk("add_rw", bus.id_reg_write, 1);
    chk("add_pc", bus.id_pc, 32'h100);
    chk("add_funct", bus.id_funct, 6'h20);
    cyc();
    @(negedge clk);
    chk("add_done_valid", bus.id_valid, 0);
    chk("add_done_ready", bus.if_ready, 1);

    // Asynchronous reset in the middle of a read.
    cyc();
    bus.if_valid = 1'b1; bus.if_instr = 32'h014B4820; bus.if_pc = 32'h104;
    cyc();
    bus.if_valid = 1'b0;
    @(negedge clk);
    chk("midrd_ready", bus.if_ready, 0);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", bus.id_valid, 0);
    chk("arst_r_en", bus.r_1_en, 0);
    chk("arst_ready", bus.if_ready, 1);
    cyc();
    rst = 1'b0;

    // Writeback bypass in READ, then a 3-cycle stall with a write to $11.
    bus.if_valid = 1'b1; bus.if_instr = 32'h014B4820; bus.if_pc = 32'h108; bus.ex_ready = 1'b0;
    cyc();
    bus.if_valid = 1'b0; bus.wb_en = 1'b1; bus.wb_addr = 5'd10; bus.wb_data = 32'h99;
    cyc();
    bus.wb_en = 1'b0;
    @(negedge clk);
    chk("byp_valid", bus.id_valid, 1);
    chk("byp_rs", bus.id_rs_data, 32'h99);
    chk("byp_rt", bus.id_rt_data, 7);
    cyc();
    bus.wb_en = 1'b1; bus.wb_addr = 5'd11; bus.wb_data = 32'h42;
    cyc();
    bus.wb_en = 1'b0;
    @(negedge clk);
    chk("stall_valid", bus.id_valid, 1);
    chk("stall_rt", bus.id_rt_data, 32'h42);
    chk("stall_rs", bus.id_rs_data, 32'h99);
    chk("stall_pc_dst", {bus.id_pc[7:0], bus.id_dst}, {8'h08, 5'd9});
    chk("stall_ready", bus.if_ready, 0);
    cyc();
    bus.ex_ready = 1'b1;
    @(negedge clk);
    chk("stall_end_valid", bus.id_valid, 1);
    chk("stall_end_rt", bus.id_rt_data, 32'h42);
    cyc();
    @(negedge clk);
    chk("stall_drain", bus.id_valid, 0);

    // add $9,$0,$11 with a writeback to $0 during READ: $0 must stay zero.
    cyc();
    bus.if_valid = 1'b1; bus.if_instr = 32'h000B4820; bus.if_pc = 32'h10C;
    cyc();
    bus.if_valid = 1'b0; bus.wb_en = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'h55;
    cyc();
    bus.wb_en = 1'b0;
    @(negedge clk);
    chk("zero_rs", bus.id_rs_data, 0);
    chk("zero_rt", bus.id_rt_data, 32'h42);
    cyc();

    // Immediate and destination decode.
    issue(32'h3528FFFF, 32'h110);
    chk("ori_imm", bus.id_imm, 32'h0000FFFF);
    chk("ori_dst", bus.id_dst, 8);
    chk("ori_rw", bus.id_reg_write, 1);
    cyc();
    issue(32'h2128FFFF, 32'h114);
    chk("addi_imm", bus.id_imm, 32'hFFFFFFFF);
    chk("addi_dst", bus.id_dst, 8);
    cyc();
    issue(32'hAD280004, 32'h118);
    chk("sw_rw", bus.id_reg_write, 0);
    chk("sw_imm", bus.id_imm, 32'h4);
    cyc();
    issue(32'h0C000010, 32'h11C);
    chk("jal_dst_rw", {bus.id_dst, bus.id_reg_write}, {5'd31, 1'b1});
    cyc();
    issue(32'h03E00008, 32'h120);
    chk("jr_rw", bus.id_reg_write, 0);
    cyc();

    // Flush during READ.
    bus.if_valid = 1'b1; bus.if_instr = 32'h014B4820; bus.if_pc = 32'h200;
    cyc();
    bus.if_valid = 1'b0; bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    @(negedge clk);
    chk("flrd_valid", bus.id_valid, 0);
    chk("flrd_ready", bus.if_ready, 1);

    // Flush during a stalled VALID.
    cyc();
    bus.ex_ready = 1'b0; bus.if_valid = 1'b1; bus.if_pc = 32'h204;
    cyc();
    bus.if_valid = 1'b0;
    cyc();
    @(negedge clk);
    chk("flv_pre_valid", bus.id_valid, 1);
    cyc();
    bus.flush = 1'b1; bus.if_valid = 1'b1;
    @(negedge clk);
    chk("flv_no_read", bus.r_1_en, 0);
    cyc();
    bus.flush = 1'b0; bus.if_valid = 1'b0; bus.ex_ready = 1'b1;
    @(negedge clk);
    chk("flv_valid", bus.id_valid, 0);
    chk("flv_ready", bus.if_ready, 1);
    cyc();
    issue(32'h014B4820, 32'h300);
    chk("post_fl_rs", bus.id_rs_data, 32'h99);
    chk("post_fl_rt", bus.id_rt_data, 32'h42);
    chk("post_fl_pc", bus.id_pc, 32'h300);
    cyc();

    // Randomized traffic against the scoreboard.
    rnd_en = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      ins = $urandom;
      ins[31:26] = ops[$urandom_range(0, 14)];
      ins[25:21] = 5'($urandom_range(0, 7));
      ins[20:16] = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) ins[5:0] = 6'h08;
      bus.if_instr = ins;
      bus.if_pc    = $urandom;
      bus.if_valid = ($urandom_range(0, 9) < 6);
      bus.ex_ready = ($urandom_range(0, 9) < 7);
      bus.flush    = ($urandom_range(0, 19) == 0);
      bus.wb_en    = ($urandom_range(0, 9) < 4);
      bus.wb_addr  = 5'($urandom_range(0, 7));
      bus.wb_data  = $urandom;
      cyc();
    end
    bus.if_valid = 1'b0; bus.flush = 1'b0; bus.ex_ready = 1'b1; bus.wb_en = 1'b0;
    repeat (4) cyc();
    rnd_en = 1'b0;
    chk("rnd_handshakes", (hs >= 100) ? 32'd1 : 32'd0, 1);
    chk("rnd_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
